// File: rtl/bcd_seg_mux2.sv
// Converts a 6-bit binary value to two BCD digits with a sequential double-dabble
// engine and time-multiplexes them onto a shared 7-segment bus.
module bcd_seg_mux2 #(
  parameter int REFRESH_DIV  = 50000,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [5:0] value,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_CONV = 1'b1;

  localparam int              CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_ZERO = 7'h3F;

  logic          r_state;
  logic [5:0]    r_bin;
  logic [7:0]    r_bcd;
  logic [2:0]    r_iter;
  logic [3:0]    r_tens;
  logic [3:0]    r_ones;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_cnt;
  logic          r_sel;
  logic [6:0]    r_seg;
  logic [1:0]    r_an;

  logic [7:0]    w_adj;
  logic [13:0]   w_shift;
  logic [7:0]    w_bcdNext;
  logic [5:0]    w_binNext;
  logic [6:0]    w_segHigh;
  logic [1:0]    w_anHigh;

  function automatic logic [6:0] encode7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // One double-dabble iteration: add 3 to any nibble >= 5, then shift {bcd, bin} left.
  assign w_adj[3:0] = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
  assign w_adj[7:4] = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
  assign w_shift    = {w_adj[6:0], r_bin, 1'b0};
  assign w_bcdNext  = w_shift[13:6];
  assign w_binNext  = w_shift[5:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_bin   <= 6'd0;
      r_bcd   <= 8'd0;
      r_iter  <= 3'd0;
      r_tens  <= 4'd0;
      r_ones  <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_bin   <= value;
            r_bcd   <= 8'd0;
            r_iter  <= 3'd0;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        default: begin
          r_bcd <= w_bcdNext;
          r_bin <= w_binNext;
          // The sixth iteration commits its own result straight to the display digits.
          if (r_iter == 3'd5) begin
            r_tens  <= w_bcdNext[7:4];
            r_ones  <= w_bcdNext[3:0];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_iter <= r_iter + 3'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sel <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_sel <= ~r_sel;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Tens digit is blanked when zero; the ones digit always shows.
  assign w_segHigh = r_sel ? ((r_tens == 4'd0) ? 7'h00 : encode7(r_tens)) : encode7(r_ones);
  assign w_anHigh  = r_sel ? 2'b10 : 2'b01;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg <= COMMON_ANODE ? ~SEG_ZERO : SEG_ZERO;
      r_an  <= COMMON_ANODE ? 2'b10 : 2'b01;
    end else begin
      r_seg <= COMMON_ANODE ? ~w_segHigh : w_segHigh;
      r_an  <= COMMON_ANODE ? ~w_anHigh : w_anHigh;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign seg  = r_seg;
  assign an   = r_an;

endmodule

// File: tb/tb_bcd_seg_mux2.sv
// Directed bench for bcd_seg_mux2: one common-anode and one common-cathode
// instance share stimulus so both output polarities are checked together.
module tb_bcd_seg_mux2;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [5:0] value = 6'd0;

  logic       busyA, doneA, busyB, doneB;
  logic [6:0] segA, segB;
  logic [1:0] anA, anB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_seg_mux2 #(.REFRESH_DIV(DIV), .COMMON_ANODE(1'b1)) dutA (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .busy(busyA), .done(doneA), .seg(segA), .an(anA)
  );

  bcd_seg_mux2 #(.REFRESH_DIV(DIV), .COMMON_ANODE(1'b0)) dutB (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .busy(busyB), .done(doneB), .seg(segB), .an(anB)
  );

  // Active-high reference patterns; 10 stands for a blanked digit.
  function automatic logic [6:0] pat(input int d);
    logic [6:0] p;
    case (d)
      0: p = 7'h3F;  1: p = 7'h06;  2: p = 7'h5B;  3: p = 7'h4F;  4: p = 7'h66;
      5: p = 7'h6D;  6: p = 7'h7D;  7: p = 7'h07;  8: p = 7'h7F;  9: p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // Pulses load with v, then waits (bounded) for done; lat is the cycle count to done.
  task automatic applyStimulus(input logic [5:0] v, output int lat);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    lat  = 1;
    while (doneA !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Records the segment pattern shown while each digit is lit on both instances.
  task automatic observe(output logic [6:0] oA, output logic [6:0] tA,
                         output logic [6:0] oB, output logic [6:0] tB,
                         output int nOnes, output int nTens);
    oA = 'x; tA = 'x; oB = 'x; tB = 'x;
    nOnes = 0; nTens = 0;
    for (int i = 0; i < 2 * DIV + 2; i++) begin
      @(negedge clk);
      if (anA === 2'b10) begin oA = segA; nOnes++; end
      else if (anA === 2'b01) begin tA = segA; nTens++; end
      if (anB === 2'b01) oB = segB;
      else if (anB === 2'b10) tB = segB;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (segA !== 7'h40 || anA !== 2'b10 || busyA !== 1'b0 || doneA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_held seg=%h an=%b busy=%b done=%b want seg=40 an=10 busy=0 done=0",
               segA, anA, busyA, doneA);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (segA !== 7'h40 || anA !== 2'b10 || busyA !== 1'b0 || doneA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release seg=%h an=%b busy=%b done=%b want seg=40 an=10 busy=0 done=0",
               segA, anA, busyA, doneA);
    end
    checks++;
    if (segB !== 7'h3F || anB !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reset_cc seg=%h an=%b want seg=3f an=01", segB, anB);
    end
  endtask

  task automatic test_conversion;
    logic [6:0] oA, tA, oB, tB;
    int nO, nT, lastChange, nChanges;
    logic [1:0] prevAn;
    @(negedge clk);
    value = 6'd15;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (k <= 6 && (busyA !== 1'b1 || doneA !== 1'b0)) begin
        errors++;
        $display("[TB] FAIL conv_busy cycle N+%0d busy=%b done=%b want busy=1 done=0", k, busyA, doneA);
      end else if (k == 7 && (busyA !== 1'b0 || doneA !== 1'b1)) begin
        errors++;
        $display("[TB] FAIL conv_done cycle N+7 busy=%b done=%b want busy=0 done=1", busyA, doneA);
      end
      @(negedge clk);
    end
    checks++;
    if (doneA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL conv_done_width done=%b want 0", doneA);
    end
    prevAn = anA;
    lastChange = -1;
    nChanges = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (anA !== prevAn) begin
        if (lastChange >= 0) begin
          checks++;
          if (c - lastChange != DIV) begin
            errors++;
            $display("[TB] FAIL refresh_period got %0d want %0d", c - lastChange, DIV);
          end
        end
        lastChange = c;
        prevAn = anA;
        nChanges++;
      end
    end
    checks++;
    if (nChanges < 4) begin
      errors++;
      $display("[TB] FAIL refresh_toggles got %0d want >=4", nChanges);
    end
    observe(oA, tA, oB, tB, nO, nT);
    checks++;
    if (oA !== ~pat(5) || tA !== ~pat(1) || nO == 0 || nT == 0) begin
      errors++;
      $display("[TB] FAIL conv_digits ones=%h tens=%h want ones=%h tens=%h", oA, tA, ~pat(5), ~pat(1));
    end
  endtask

  task automatic test_blanking;
    logic [6:0] oA, tA, oB, tB;
    int nO, nT, lat, t, o;
    logic [5:0] vals [3];
    vals = '{6'd7, 6'd63, 6'd0};
    for (int i = 0; i < 3; i++) begin
      t = int'(vals[i]) / 10;
      o = int'(vals[i]) % 10;
      applyStimulus(vals[i], lat);
      checks++;
      if (lat != 7) begin
        errors++;
        $display("[TB] FAIL blank_latency v=%0d got %0d want 7", vals[i], lat);
      end
      @(negedge clk);
      observe(oA, tA, oB, tB, nO, nT);
      checks++;
      if (oA !== ~pat(o) || tA !== ~pat(t == 0 ? 10 : t) || nO == 0 || nT == 0) begin
        errors++;
        $display("[TB] FAIL blank_digits v=%0d ones=%h tens=%h want ones=%h tens=%h",
                 vals[i], oA, tA, ~pat(o), ~pat(t == 0 ? 10 : t));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] oA, tA, oB, tB;
    int nO, nT, lat, nDone;
    @(negedge clk);
    value = 6'd12;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    nDone = 0;
    for (int k = 1; k <= 12; k++) begin
      if (doneA === 1'b1) nDone++;
      if (k == 3) begin
        value = 6'd40;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (nDone != 1) begin
      errors++;
      $display("[TB] FAIL busy_load_done_count got %0d want 1", nDone);
    end
    observe(oA, tA, oB, tB, nO, nT);
    checks++;
    if (oA !== ~pat(2) || tA !== ~pat(1)) begin
      errors++;
      $display("[TB] FAIL busy_load_digits ones=%h tens=%h want ones=%h tens=%h", oA, tA, ~pat(2), ~pat(1));
    end
    applyStimulus(6'd5, lat);
    value = 6'd40;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    lat  = 1;
    while (doneA !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 7) begin
      errors++;
      $display("[TB] FAIL reload_on_done latency got %0d want 7", lat);
    end
    @(negedge clk);
    observe(oA, tA, oB, tB, nO, nT);
    checks++;
    if (oA !== ~pat(0) || tA !== ~pat(4)) begin
      errors++;
      $display("[TB] FAIL reload_digits ones=%h tens=%h want ones=%h tens=%h", oA, tA, ~pat(0), ~pat(4));
    end
  endtask

  task automatic test_reset_mid_conv;
    int nDone;
    @(negedge clk);
    value = 6'd33;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busyA !== 1'b0 || doneA !== 1'b0 || segA !== 7'h40 || anA !== 2'b10) begin
      errors++;
      $display("[TB] FAIL midreset busy=%b done=%b seg=%h an=%b want busy=0 done=0 seg=40 an=10",
               busyA, doneA, segA, anA);
    end
    rst_n = 1'b1;
    nDone = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (doneA === 1'b1) nDone++;
      checks++;
      if (anA !== 2'b10) begin
        errors++;
        $display("[TB] FAIL midreset_refresh cycle %0d an=%b want 10", k, anA);
      end
    end
    @(negedge clk);
    if (doneA === 1'b1) nDone++;
    checks++;
    if (anA !== 2'b01 || segA !== 7'h7F) begin
      errors++;
      $display("[TB] FAIL midreset_tens an=%b seg=%h want an=01 seg=7f", anA, segA);
    end
    repeat (4) begin
      @(negedge clk);
      if (doneA === 1'b1) nDone++;
    end
    checks++;
    if (nDone != 0) begin
      errors++;
      $display("[TB] FAIL midreset_no_done got %0d pulses want 0", nDone);
    end
  endtask

  task automatic test_sweep;
    logic [6:0] oA, tA, oB, tB;
    int nO, nT, lat, t, o, eT;
    for (int v = 0; v < 64; v++) begin
      t  = v / 10;
      o  = v % 10;
      eT = (t == 0) ? 10 : t;
      applyStimulus(6'(v), lat);
      checks++;
      if (lat != 7) begin
        errors++;
        $display("[TB] FAIL sweep_latency v=%0d got %0d want 7", v, lat);
      end
      @(negedge clk);
      observe(oA, tA, oB, tB, nO, nT);
      checks++;
      if (oA !== ~pat(o) || tA !== ~pat(eT) || nO == 0 || nT == 0) begin
        errors++;
        $display("[TB] FAIL sweep_ca v=%0d ones=%h tens=%h want ones=%h tens=%h", v, oA, tA, ~pat(o), ~pat(eT));
      end
      checks++;
      if (oB !== pat(o) || tB !== pat(eT)) begin
        errors++;
        $display("[TB] FAIL sweep_cc v=%0d ones=%h tens=%h want ones=%h tens=%h", v, oB, tB, pat(o), pat(eT));
      end
    end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_blanking();
    test_back_to_back();
    test_reset_mid_conv();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
